// File: rtl/deca_pkg.sv
// Shared types and constants for the DECA control path.
// Latency: n/a (types only).
// Backpressure: n/a.
package deca_pkg;

    localparam int DATA_W_D = 16;
    localparam int OPC_W_D  = 4;
    localparam int ADDR_W_D = 12;
    localparam int CNT_W_D  = 16;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC1 = 2'd1,
        S_EXEC2 = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_STA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_JMP = 4'h4;
    localparam logic [3:0] OP_JMI = 4'h5;
    localparam logic [3:0] OP_JEQ = 4'h6;
    localparam logic [3:0] OP_STP = 4'h7;
    localparam logic [3:0] OP_LDI = 4'h8;
    localparam logic [3:0] OP_LSR = 4'hA;
    localparam logic [3:0] OP_ASR = 4'hB;

    // Returns {halted, exec2, exec1, fetch} for a state.
    function automatic logic [3:0] state_strobes(input state_t s);
        case (s)
            S_FETCH: return 4'b0001;
            S_EXEC1: return 4'b0010;
            S_EXEC2: return 4'b0100;
            default: return 4'b1000;
        endcase
    endfunction

endpackage

// File: rtl/cycle_sequencer_if.sv
// Sequencer <-> decoder/RAM bundle: cycle strobes and IR out, EXTRA/canPipeline/RAM data in.
// Latency: n/a (wires only).
// Backpressure: none; strobes are level signals.
interface cycle_sequencer_if #(
    parameter int DATA_W = deca_pkg::DATA_W_D,
    parameter int OPC_W  = deca_pkg::OPC_W_D,
    parameter int ADDR_W = deca_pkg::ADDR_W_D
);
    logic              EXTRA;
    logic              canPipeline;
    logic [DATA_W-1:0] RAM_Q;
    logic              FETCH;
    logic              EXEC1;
    logic              EXEC2;
    logic [OPC_W-1:0]  IR;
    logic [ADDR_W-1:0] N;
    logic              BeenPipelined;

    modport master (
        input  EXTRA, canPipeline, RAM_Q,
        output FETCH, EXEC1, EXEC2, IR, N, BeenPipelined
    );

    modport slave (
        output EXTRA, canPipeline, RAM_Q,
        input  FETCH, EXEC1, EXEC2, IR, N, BeenPipelined
    );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter; sticks at all-ones instead of wrapping.
// Latency: q reflects inc one cycle later.
// Backpressure: none.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] q
);
    always_ff @(posedge clk) begin
        if (reset)
            q <= '0;
        else if (inc && (q != {W{1'b1}}))
            q <= q + W'(1);
    end
endmodule

// File: rtl/cycle_sequencer.sv
// FETCH/EXEC1/EXEC2 sequencer for the DECA CPU: owns IR/N, STP halt, run/step gating, statistics.
// Latency: IR valid the cycle after its load edge; instructions take 2 cycles, 3 with EXTRA.
// Backpressure: run=0 freezes all state; each rising edge of step releases a single advance.
module cycle_sequencer
    import deca_pkg::*;
#(
    parameter int DATA_W = DATA_W_D,
    parameter int OPC_W  = OPC_W_D,
    parameter int ADDR_W = ADDR_W_D,
    parameter int CNT_W  = CNT_W_D
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             step,
    cycle_sequencer_if.master dec,
    output logic             HALTED,
    output logic [CNT_W-1:0] CYCLES,
    output logic [CNT_W-1:0] RETIRED
);
    state_t            state, state_nxt;
    logic              step_q;
    logic              adv, live, is_stp, final_exec, load, retire_inc;
    logic              fetch_q, exec1_q, exec2_q, halted_q;
    logic [OPC_W-1:0]  ir_q;
    logic [ADDR_W-1:0] n_q;
    logic              bp_q;

    always_ff @(posedge clk) begin
        if (reset)
            step_q <= 1'b0;
        else
            step_q <= step;
    end

    assign adv    = run | (step & ~step_q);
    assign live   = adv && (state != S_HALT);
    assign is_stp = (ir_q == OPC_W'(OP_STP));

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH: if (adv) state_nxt = S_EXEC1;
            S_EXEC1: if (adv) state_nxt = is_stp ? S_HALT : (dec.EXTRA ? S_EXEC2 : S_FETCH);
            S_EXEC2: if (adv) state_nxt = S_FETCH;
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_FETCH;
        endcase
    end

    // STP is excluded from the pipelined load: the machine stops there.
    assign final_exec = ((state == S_EXEC1) && !dec.EXTRA && !is_stp) || (state == S_EXEC2);
    assign load       = live && (((state == S_FETCH) && !bp_q) || (final_exec && dec.canPipeline));
    assign retire_inc = live && (((state == S_EXEC1) && (is_stp || !dec.EXTRA)) || (state == S_EXEC2));

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_FETCH;
            fetch_q  <= 1'b1;
            exec1_q  <= 1'b0;
            exec2_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state <= state_nxt;
            {halted_q, exec2_q, exec1_q, fetch_q} <= state_strobes(state_nxt);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ir_q <= '0;
            n_q  <= '0;
            bp_q <= 1'b0;
        end else begin
            if (load) begin
                ir_q <= dec.RAM_Q[DATA_W-1 -: OPC_W];
                n_q  <= dec.RAM_Q[ADDR_W-1:0];
            end
            if (live)
                bp_q <= (state_nxt == S_HALT) ? 1'b0 : dec.canPipeline;
        end
    end

    sat_counter #(.W(CNT_W)) u_cycles (
        .clk   (clk),
        .reset (reset),
        .inc   (live),
        .q     (CYCLES)
    );

    sat_counter #(.W(CNT_W)) u_retired (
        .clk   (clk),
        .reset (reset),
        .inc   (retire_inc),
        .q     (RETIRED)
    );

    assign dec.FETCH         = fetch_q;
    assign dec.EXEC1         = exec1_q;
    assign dec.EXEC2         = exec2_q;
    assign dec.IR            = ir_q;
    assign dec.N             = n_q;
    assign dec.BeenPipelined = bp_q;
    assign HALTED            = halted_q;
endmodule

// File: doc/cycle_sequencer.md
Name: cycle_sequencer

Overview:
- Control-state generator on the other side of the instruction decoder. It consumes the decoder's EXTRA and canPipeline lines and drives the FETCH/EXEC1/EXEC2 cycle strobes back into it.
- Owns the instruction register (opcode IR plus operand N), latched from the RAM read port.
- Handles the STP halt, run/single-step gating, and cycle/retired-instruction statistics for the DECA CPU.

Parameters:
- DATA_W, 16, RAM word width; the instruction word is opcode in the top OPC_W bits and operand in the remainder.
- OPC_W, 4, opcode width.
- ADDR_W, 12, operand (N) width; must equal DATA_W-OPC_W.
- CNT_W, 16, width of the saturating statistics counters.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- run  in  1  1 = free-running; 0 = stalled unless step pulses
- step  in  1  advance exactly one state while run=0
- EXTRA  in  1  from decoder: current instruction needs EXEC2
- canPipeline  in  1  from decoder: next instruction is fetched during this cycle
- RAM_Q  in  DATA_W  RAM read data
- FETCH  out  1  state strobe
- EXEC1  out  1  state strobe
- EXEC2  out  1  state strobe
- IR  out  OPC_W  registered opcode to decoder
- N  out  ADDR_W  registered operand
- HALTED  out  1  STP executed
- BeenPipelined  out  1  registered copy of canPipeline
- CYCLES  out  CNT_W  advancing-cycle count, saturating
- RETIRED  out  CNT_W  completed-instruction count, saturating

Behaviour:
- Reset (synchronous, highest priority, legal mid-instruction):
  - state=S_FETCH, so FETCH=1, EXEC1=0, EXEC2=0.
  - IR=0, N=0, HALTED=0, BeenPipelined=0, CYCLES=0, RETIRED=0.
- States: S_FETCH, S_EXEC1, S_EXEC2, S_HALT. Strobes are a one-hot decode of the state register; all three are 0 in S_HALT.
- adv = run | step. When adv=0, nothing changes:
  - no state change, no IR/N load, counters frozen;
  - BeenPipelined holds.
- run=1 with step=1: step is ignored. Each step pulse gives exactly one advance, even if held high for several cycles (rising-edge detect on step).
- Transitions, applied only when adv=1:
  - S_FETCH -> S_EXEC1.
  - S_EXEC1 -> S_HALT if IR==OP_STP.
  - S_EXEC1 -> S_EXEC2 if EXTRA.
  - S_EXEC1 -> S_FETCH otherwise.
  - S_EXEC2 -> S_FETCH.
  - S_HALT -> S_HALT. Only reset exits; run and step are ignored.
- IR/N load, applied only when adv=1:
  - In S_FETCH with BeenPipelined=0: IR<=RAM_Q[DATA_W-1 -: OPC_W], N<=RAM_Q[ADDR_W-1:0].
  - In S_FETCH with BeenPipelined=1: no load, because that instruction was already loaded in the previous exec cycle.
  - In the final exec cycle (S_EXEC1 without EXTRA, or S_EXEC2) with canPipeline=1: IR/N load from RAM_Q.
  - No load in S_HALT.
- BeenPipelined <= canPipeline on every advancing cycle. It is forced to 0 on entry to S_HALT.
- RETIRED increments on leaving S_EXEC1 toward S_FETCH, on leaving S_EXEC2, and on entering S_HALT (STP counts).
- CYCLES increments on every advancing cycle outside S_HALT.
- Both counters saturate at 2^CNT_W-1 and never wrap.
- HALTED = (state==S_HALT), registered. It asserts the cycle after the STP EXEC1 edge.
- Latency:
  - IR is valid in the cycle after the loading edge.
  - Non-pipelined instruction: 2 cycles without EXTRA, 3 cycles with EXTRA.
- Illegal state encodings recover to S_FETCH on the next clock.

Decomposition:
- Package deca_pkg:
  - state enum {S_FETCH, S_EXEC1, S_EXEC2, S_HALT}, 2-bit encoding.
  - opcode constants OP_LDA=0, OP_STA=1, OP_ADD=2, OP_SUB=3, OP_JMP=4, OP_JMI=5, OP_JEQ=6, OP_STP=7, OP_LDI=8, OP_LSR=10, OP_ASR=11.
  - default widths.
- Sub-module sat_counter (parameter W; ports clk, reset, inc, q), instantiated twice for CYCLES and RETIRED.

Test Plan:
1. Reset, run=1, RAM_Q=0x8005 (LDI 5), EXTRA=0 -> strobes FETCH, EXEC1, FETCH; IR=8 and N=0x005 after the first edge; RETIRED=1 after 2 cycles.
2. RAM_Q=0x2010 (ADD), EXTRA=1 in EXEC1 -> FETCH, EXEC1, EXEC2, FETCH; CYCLES=3, RETIRED=1.
3. Final exec cycle with canPipeline=1 and RAM_Q=0xA000 (LSR) -> IR=0xA next cycle, BeenPipelined=1, following FETCH does not reload even if RAM_Q=0x0000.
4. RAM_Q=0x7000 (STP) -> after EXEC1: HALTED=1, all strobes 0; RETIRED increments once; then run=1 and step pulses give no change; reset returns FETCH=1, HALTED=0.
5. run=0 -> state frozen, including with step held high for 5 cycles except a single advance on its rising edge; CYCLES increments by exactly 1.
6. Force CNT_W=4 and run 20 instructions -> CYCLES and RETIRED hold at 15; assert reset in S_EXEC2 -> next cycle FETCH=1 and all counters 0.
